// File: rtl/spi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_bridge                                                      |
// | Purpose  : SPI mode-0 slave (MSB first) acting as initiator for the PWM    |
// |            register file. Frame = command byte then one data byte.         |
// |            Command bit7 = write, bits5:0 = address. Reads return the       |
// |            register data on miso during the data byte.                     |
// | Ports    : clk, rst_n            system clock / async active-low reset     |
// |            sclk_i, cs_n_i, mosi_i SPI pins, asynchronous to clk            |
// |            miso_o                SPI data out, 0 when deselected           |
// |            read_o, write_o       one-clk strobes to the register file      |
// |            addr_o[5:0]           register address                          |
// |            data_read_i[7:0]      read data, valid while read_o=1           |
// |            data_write_o[7:0]     write data, stable while write_o=1        |
// |            busy_o                frame in progress                         |
// | Macro    : SPI_AUTOINC_EN - burst mode, address auto-increments per byte  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       read_o,
  output logic       write_o,
  output logic [5:0] addr_o,
  input  logic [7:0] data_read_i,
  output logic [7:0] data_write_o,
  output logic       busy_o
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CMD  = 2'd1;
  localparam logic [1:0] c_DATA = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_shift_q;
  logic [7:0] tx_shift_q;
  logic       miso_q;
  logic       read_q;
  logic       write_q;
  logic       is_write_q;
  logic [5:0] addr_q;
  logic [7:0] data_write_q;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic       byte_done;
  logic [7:0] rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign rx_next   = {rx_shift_q[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  // cs_n chain resets low so that a cs_n already low at reset release is not
  // mistaken for a falling edge; only a genuine high-to-low starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = c_IDLE;
    end else begin
      case (state_q)
        c_IDLE: if (cs_fall) state_d = c_CMD;
        c_CMD:  if (byte_done) state_d = c_DATA;
`ifdef SPI_AUTOINC_EN
        c_DATA: state_d = c_DATA;
`else
        c_DATA: if (byte_done) state_d = c_DONE;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath: shifting, address/data latching and strobe generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 8'd0;
      tx_shift_q   <= 8'd0;
      miso_q       <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      is_write_q   <= 1'b0;
      addr_q       <= 6'd0;
      data_write_q <= 8'd0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      if (state_q != c_DATA) miso_q <= 1'b0;
      if (!cs_rise) begin
        case (state_q)
          c_IDLE: begin
            if (cs_fall) begin
              bit_cnt_q  <= 3'd0;
              rx_shift_q <= 8'd0;
            end
          end
          c_CMD: begin
            if (sclk_rise) begin
              rx_shift_q <= rx_next;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                addr_q     <= rx_next[5:0];
                is_write_q <= rx_next[7];
                tx_shift_q <= 8'd0;
                read_q     <= ~rx_next[7];
              end
            end
          end
          c_DATA: begin
            if (sclk_fall) begin
              miso_q     <= tx_shift_q[7];
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_shift_q <= rx_next;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (is_write_q) begin
                  data_write_q <= rx_next;
                  write_q      <= 1'b1;
                end
`ifdef SPI_AUTOINC_EN
                else begin
                  // Pre-fetch the next register for the following byte.
                  addr_q <= addr_q + 6'd1;
                  read_q <= 1'b1;
                end
`endif
              end
            end
          end
          default: ;
        endcase
      end
`ifdef SPI_AUTOINC_EN
      // Writes advance the address once their strobe has been seen.
      if (write_q) addr_q <= addr_q + 6'd1;
`endif
      // Register-file data is captured in the strobe cycle; sclk is slow
      // enough that no sclk fall can coincide with this cycle.
      if (read_q) tx_shift_q <= data_read_i;
    end
  end

  // Output logic
  always_comb begin
    busy_o       = (state_q != c_IDLE);
    miso_o       = miso_q & (state_q == c_DATA) & ~cs_s;
    read_o       = read_q;
    write_o      = write_q;
    addr_o       = addr_q;
    data_write_o = data_write_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spi_bridge                                                   |
// | Purpose  : Directed self-checking bench for spi_bridge. Acts as SPI        |
// |            master and as a register-file responder; logs strobes.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_spi_bridge;

  localparam int HALF = 80; // sclk half period: 8 clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_read;
  logic [7:0] data_write;
  logic       busy;

  logic [7:0] mem [64];

  int errors = 0;
  int checks = 0;

  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         both_cnt = 0;
  logic [5:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];
  logic [5:0] rd_addr_log [16];

  spi_bridge #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk_i       (sclk),
    .cs_n_i       (cs_n),
    .mosi_i       (mosi),
    .miso_o       (miso),
    .read_o       (read),
    .write_o      (write),
    .addr_o       (addr),
    .data_read_i  (data_read),
    .data_write_o (data_write),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  assign data_read = mem[addr];

  always @(negedge clk) begin
    if (write) begin
      wr_addr_log[wr_cnt % 16] = addr;
      wr_data_log[wr_cnt % 16] = data_write;
      wr_cnt = wr_cnt + 1;
    end
    if (read) begin
      rd_addr_log[rd_cnt % 16] = addr;
      rd_cnt = rd_cnt + 1;
    end
    if (read && write) both_cnt = both_cnt + 1;
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'd0;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #HALF;
      r = {r[6:0], miso};
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic bad;
    bad = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sclk = ~sclk;
      mosi = i[0];
      cs_n = i[2];
      #20;
      if (miso !== 1'b0 || read !== 1'b0 || write !== 1'b0 || busy !== 1'b0 || addr !== 6'd0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_hold: some output nonzero during reset, got=1 want=0");
    end
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #30 rst_n = 1'b1;
    #50;
    checks++;
    if (data_write !== 8'd0) begin
      errors++;
      $display("FAIL reset_data_write: got=%h want=00", data_write);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got=%b want=0", busy);
    end
  endtask

  task automatic test_idle_sclk();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      mosi = 1'b1; sclk = 1'b1; #HALF; sclk = 1'b0; #HALF;
    end
    checks++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin
      errors++;
      $display("FAIL idle_sclk_strobes: got=%0d want=0", (wr_cnt - w0) + (rd_cnt - r0));
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_sclk_busy: got=%b want=0", busy);
    end
  endtask

  task automatic test_write();
    int w0, r0;
    logic [7:0] r;
    w0 = wr_cnt; r0 = rd_cnt;
    cs_n = 1'b0;
    #50;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL write_busy: got=%b want=1", busy);
    end
    spi_bits(8'h82, 8, r);
    spi_bits(8'h5A, 8, r);
    #HALF cs_n = 1'b1;
    #100;
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL write_count: got=%0d want=1", wr_cnt - w0);
    end
    checks++;
    if (wr_addr_log[w0 % 16] !== 6'h02 || wr_data_log[w0 % 16] !== 8'h5A) begin
      errors++;
      $display("FAIL write_addr_data: got=%h/%h want=02/5a",
               wr_addr_log[w0 % 16], wr_data_log[w0 % 16]);
    end
    checks++;
    if (rd_cnt - r0 !== 0) begin
      errors++;
      $display("FAIL write_no_read: got=%0d want=0", rd_cnt - r0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL write_busy_end: got=%b want=0", busy);
    end
  endtask

  task automatic test_read();
    int w0, r0, exp_rd;
    logic [7:0] r;
    w0 = wr_cnt; r0 = rd_cnt;
    mem[6'h0D] = 8'hC3;
`ifdef SPI_AUTOINC_EN
    exp_rd = 2; // the 8th data rise pre-fetches the next register
`else
    exp_rd = 1;
`endif
    cs_n = 1'b0;
    #50;
    spi_bits(8'h0D, 8, r);
    spi_bits(8'h00, 8, r);
    checks++;
    if (r !== 8'hC3) begin
      errors++;
      $display("FAIL read_miso_data: got=%h want=c3", r);
    end
    #HALF cs_n = 1'b1;
    #100;
    checks++;
    if (rd_cnt - r0 !== exp_rd) begin
      errors++;
      $display("FAIL read_count: got=%0d want=%0d", rd_cnt - r0, exp_rd);
    end
    checks++;
    if (rd_addr_log[r0 % 16] !== 6'h0D) begin
      errors++;
      $display("FAIL read_addr: got=%h want=0d", rd_addr_log[r0 % 16]);
    end
    checks++;
    if (wr_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL read_no_write: got=%0d want=0", wr_cnt - w0);
    end
    checks++;
    if (miso !== 1'b0) begin
      errors++;
      $display("FAIL read_miso_idle: got=%b want=0", miso);
    end
  endtask

  task automatic test_abort();
    int w0;
    logic [7:0] r;
    w0 = wr_cnt;
    cs_n = 1'b0;
    #50;
    spi_bits(8'h81, 8, r);
    spi_bits(8'hFF, 5, r);
    #HALF cs_n = 1'b1;
    #200;
    checks++;
    if (wr_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL abort_no_write: got=%0d want=0", wr_cnt - w0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got=%b want=0", busy);
    end
    cs_n = 1'b0;
    #50;
    spi_bits(8'h81, 8, r);
    spi_bits(8'h12, 8, r);
    #HALF cs_n = 1'b1;
    #100;
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL abort_next_count: got=%0d want=1", wr_cnt - w0);
    end
    checks++;
    if (wr_addr_log[w0 % 16] !== 6'h01 || wr_data_log[w0 % 16] !== 8'h12) begin
      errors++;
      $display("FAIL abort_next_write: got=%h/%h want=01/12",
               wr_addr_log[w0 % 16], wr_data_log[w0 % 16]);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    logic [7:0] r;
    w0 = wr_cnt;
    cs_n = 1'b0;
    #50;
    spi_bits(8'h85, 8, r);
    spi_bits(8'hF0, 4, r);
    #20 rst_n = 1'b0;
    #30;
    checks++;
    if (busy !== 1'b0 || addr !== 6'd0 || data_write !== 8'd0 || miso !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b addr=%h dw=%h want 0/00/00",
               busy, addr, data_write);
    end
    rst_n = 1'b1;
    #50;
    // cs_n still low: further clocking must not produce a strobe
    spi_bits(8'hF0, 4, r);
    spi_bits(8'h85, 8, r);
    spi_bits(8'h77, 8, r);
    #100;
    checks++;
    if (wr_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL midreset_no_strobe: got=%0d want=0", wr_cnt - w0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_busy: got=%b want=0", busy);
    end
    cs_n = 1'b1;
    #100 cs_n = 1'b0;
    #50;
    spi_bits(8'h85, 8, r);
    spi_bits(8'h66, 8, r);
    #HALF cs_n = 1'b1;
    #100;
    checks++;
    if (wr_cnt - w0 !== 1 || wr_addr_log[w0 % 16] !== 6'h05 || wr_data_log[w0 % 16] !== 8'h66) begin
      errors++;
      $display("FAIL midreset_new_frame: got cnt=%0d %h/%h want 1 05/66",
               wr_cnt - w0, wr_addr_log[w0 % 16], wr_data_log[w0 % 16]);
    end
  endtask

  task automatic test_burst();
    int w0, exp_wr;
    logic [7:0] r;
    w0 = wr_cnt;
`ifdef SPI_AUTOINC_EN
    exp_wr = 2;
`else
    exp_wr = 1;
`endif
    cs_n = 1'b0;
    #50;
    spi_bits(8'hBF, 8, r);
    spi_bits(8'h11, 8, r);
    spi_bits(8'h22, 8, r);
    #HALF cs_n = 1'b1;
    #100;
    checks++;
    if (wr_cnt - w0 !== exp_wr) begin
      errors++;
      $display("FAIL burst_count: got=%0d want=%0d", wr_cnt - w0, exp_wr);
    end
    checks++;
    if (wr_addr_log[w0 % 16] !== 6'h3F || wr_data_log[w0 % 16] !== 8'h11) begin
      errors++;
      $display("FAIL burst_first: got=%h/%h want=3f/11",
               wr_addr_log[w0 % 16], wr_data_log[w0 % 16]);
    end
`ifdef SPI_AUTOINC_EN
    checks++;
    if (wr_addr_log[(w0 + 1) % 16] !== 6'h00 || wr_data_log[(w0 + 1) % 16] !== 8'h22) begin
      errors++;
      $display("FAIL burst_second: got=%h/%h want=00/22",
               wr_addr_log[(w0 + 1) % 16], wr_data_log[(w0 + 1) % 16]);
    end
`endif
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL read_write_overlap: got=%0d want=0", both_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    test_reset();
    test_idle_sclk();
    test_write();
    test_read();
    test_abort();
    test_reset_mid();
    test_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
